// File: rtl/oversample_ctrl_if.sv
// Sample-in / result-out bundle of the oversampling controller.
// Slave side is the controller, master side drives conversions and consumes words.
interface oversample_ctrl_if #(
    parameter int NCH = 2
) ();
    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [11:0]   sample;
    logic [4:0]    channel;
    logic          eoc;
    logic [15:0]   out_data;
    logic [LW-1:0] out_lane;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output sample, channel, eoc, out_ready,
        input  out_data, out_lane, out_valid
    );

    modport slave (
        input  sample, channel, eoc, out_ready,
        output out_data, out_lane, out_valid
    );
endinterface

// File: rtl/oversample_ctrl.sv
// Per-channel XADC oversampling lanes (x1/x16/x256) feeding a small
// first-word-fall-through result FIFO with valid/ready output.
module oversample_ctrl #(
    parameter int         NCH        = 2,
    parameter logic [4:0] CH_BASE    = 5'd3,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_mode,
    oversample_ctrl_if.slave bus,
    output logic        overflow,
    output logic        busy
);
    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_OFF, S_RUN, S_RECONF} state_t;

    state_t        state_q, state_d;
    logic [1:0]    active_q;
    logic [19:0]   acc_q [NCH];
    logic [19:0]   acc_d [NCH];
    logic [7:0]    cnt_q [NCH];
    logic [7:0]    cnt_d [NCH];
    logic          busy_d;

    logic          cfg_ok;
    logic [5:0]    ch_off;
    logic          hit;
    logic [LW-1:0] sel;
    logic          take;
    logic [19:0]   total;
    logic [19:0]   rnd;
    logic [15:0]   norm;
    logic [7:0]    last;
    logic          push;

    assign cfg_ok = cfg_enable && (cfg_mode != 2'b11);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF:    if (cfg_ok) state_d = S_RECONF;
            S_RUN: begin
                if (!cfg_ok)                   state_d = S_OFF;
                else if (cfg_mode != active_q) state_d = S_RECONF;
            end
            S_RECONF: state_d = S_RUN;
            default:  state_d = S_OFF;
        endcase
    end

    assign ch_off = {1'b0, bus.channel} - {1'b0, CH_BASE};
    assign hit    = ({1'b0, bus.channel} >= {1'b0, CH_BASE}) && (ch_off < 6'(NCH));
    assign sel    = ch_off[LW-1:0];
    // A strobe on the cycle RUN is being left belongs to the old mode.
    assign take   = bus.eoc && hit && (state_q == S_RUN) && (state_d == S_RUN);
    assign total  = acc_q[sel] + {8'd0, bus.sample};

    always_comb begin
        last = 8'd255;
        rnd  = total + 20'd8;
        norm = 16'(rnd >> 4);
        unique case (active_q)
            2'b00: begin
                last = 8'd0;
                norm = {bus.sample, 4'h0};
            end
            2'b01: begin
                last = 8'd15;
                rnd  = total + 20'd2;
                norm = 16'(rnd & ~20'd3);
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (state_q != S_RUN) begin
            for (int i = 0; i < NCH; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
        end else if (take) begin
            if (cnt_q[sel] == last) begin
                push       = 1'b1;
                acc_d[sel] = '0;
                cnt_d[sel] = '0;
            end else begin
                acc_d[sel] = total;
                cnt_d[sel] = cnt_q[sel] + 8'd1;
            end
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (cnt_d[i] != 8'd0) busy_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            active_q <= 2'b00;
            busy     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_RECONF) active_q <= cfg_mode;
            busy  <= busy_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    logic [15:0]   mem_data [FIFO_DEPTH];
    logic [LW-1:0] mem_lane [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] fcnt_q;
    logic          full, pop, wr_en;

    assign full  = (fcnt_q == CW'(FIFO_DEPTH));
    assign pop   = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_q] <= norm;
            mem_lane[wr_q] <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            fcnt_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            fcnt_q <= fcnt_q + CW'(wr_en) - CW'(pop);
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    assign bus.out_valid = (fcnt_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_data[rd_q] : '0;
    assign bus.out_lane  = bus.out_valid ? mem_lane[rd_q] : '0;
endmodule

// File: tb/tb_oversample_ctrl.sv
// Directed bench for oversample_ctrl with a cycle-level behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_oversample_ctrl;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int BASE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_enable = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic       overflow, busy;

    oversample_ctrl_if #(.NCH(NCH)) bus ();

    oversample_ctrl #(
        .NCH(NCH), .CH_BASE(5'd3), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .bus(bus), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        int          lane;
    } word_t;

    word_t      q[$];
    int         m_acc[NCH];
    int         m_cnt[NCH];
    bit         app_ok, hold, m_ovf, started;
    logic [1:0] app_mode;

    function automatic bit m_busy();
        for (int i = 0; i < NCH; i++)
            if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Config changes blank the lanes for two strobes; partial sums drop one cycle later.
    always @(posedge clk) begin
        bit    en_ok, acc_ok, pop, done;
        int    ch, ln, n, tot;
        word_t w;
        if (rst) begin
            q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end
            app_ok = 0; app_mode = 2'b00; hold = 0; m_ovf = 0; started = 1;
        end else begin
            pop    = (q.size() > 0) && bus.out_ready;
            en_ok  = cfg_enable && (cfg_mode != 2'b11);
            acc_ok = 0;
            done   = 0;
            if (en_ok != app_ok || (en_ok && cfg_mode != app_mode)) begin
                app_ok = en_ok; app_mode = cfg_mode; hold = en_ok;
            end else if (!app_ok || hold) begin
                for (int i = 0; i < NCH; i++) begin
                    m_acc[i] = 0;
                    m_cnt[i] = 0;
                end
                hold = 0;
            end else acc_ok = 1;
            ch = int'(bus.channel);
            if (acc_ok && bus.eoc && ch >= BASE && ch < BASE + NCH) begin
                ln  = ch - BASE;
                n   = (app_mode == 2'b00) ? 1 : (app_mode == 2'b01) ? 16 : 256;
                tot = m_acc[ln] + int'(bus.sample);
                if (m_cnt[ln] + 1 == n) begin
                    done   = 1;
                    w.lane = ln;
                    if (n == 1)       w.d = 16'(int'(bus.sample) * 16);
                    else if (n == 16) w.d = 16'(((tot + 2) / 4) * 4);
                    else              w.d = 16'((tot + 8) / 16);
                    m_acc[ln] = 0;
                    m_cnt[ln] = 0;
                end else begin
                    m_acc[ln] = tot;
                    m_cnt[ln] = m_cnt[ln] + 1;
                end
            end
            if (done && !(q.size() < DEPTH || pop)) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (done && (q.size() < DEPTH)) q.push_back(w);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_valid", bus.out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("model_data", bus.out_data, q[0].d);
                chk("model_lane", bus.out_lane, q[0].lane);
            end
            chk("model_overflow", overflow, m_ovf);
            chk("model_busy", busy, m_busy());
        end
    end

    task automatic step(input bit e, input logic [4:0] ch, input logic [11:0] s);
        @(posedge clk);
        #2;
        bus.eoc = e; bus.channel = ch; bus.sample = s;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 12'h000);
    endtask

    initial begin
        bus.eoc = 1'b0; bus.channel = '0; bus.sample = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_lane", bus.out_lane, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);

        @(posedge clk); #2;
        rst = 1'b0; cfg_enable = 1'b1; cfg_mode = 2'b00;
        idle(3);
        step(1'b1, 5'd3, 12'h123);
        step(1'b1, 5'd7, 12'h456);
        @(negedge clk);
        chk("x1_valid", bus.out_valid, 1);
        chk("x1_data", bus.out_data, 16'h1230);
        chk("x1_lane", bus.out_lane, 0);
        idle(2);
        @(negedge clk);
        chk("x1_ch7_ignored", bus.out_valid, 0);

        cfg_mode = 2'b01;
        idle(3);
        step(1'b1, 5'd4, 12'h800);
        step(1'b1, 5'd4, 12'h800);
        @(negedge clk);
        chk("x16_busy_mid", busy, 1);
        repeat (14) step(1'b1, 5'd4, 12'h800);
        idle(1);
        @(negedge clk);
        chk("x16_data", bus.out_data, 16'h8000);
        chk("x16_lane", bus.out_lane, 1);
        chk("x16_busy_end", busy, 0);
        idle(2);
        @(negedge clk);
        chk("x16_one_word", bus.out_valid, 0);

        cfg_mode = 2'b10;
        idle(3);
        repeat (256) step(1'b1, 5'd3, 12'hFFF);
        idle(1);
        @(negedge clk);
        chk("x256_full", bus.out_data, 16'hFFF0);
        idle(1);
        for (int i = 0; i < 256; i++) step(1'b1, 5'd3, 12'(i % 2));
        idle(1);
        @(negedge clk);
        chk("x256_alt", bus.out_data, 16'h0008);

        cfg_mode = 2'b01;
        idle(3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            step(1'b1, (i % 2) ? 5'd4 : 5'd3, (i % 2) ? 12'h020 : 12'h010);
        idle(1);
        @(negedge clk);
        chk("ilv_first_data", bus.out_data, 16'h0100);
        chk("ilv_first_lane", bus.out_lane, 0);
        bus.out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk("ilv_second_data", bus.out_data, 16'h0200);
        chk("ilv_second_lane", bus.out_lane, 1);
        idle(2);

        repeat (10) step(1'b1, 5'd3, 12'h100);
        step(1'b1, 5'd3, 12'h100);
        cfg_mode = 2'b10;
        step(1'b1, 5'd3, 12'h100);
        repeat (16) step(1'b1, 5'd3, 12'h100);
        idle(1);
        @(negedge clk);
        chk("reconf_no_out", bus.out_valid, 0);
        chk("reconf_busy", busy, 1);
        bus.out_ready = 1'b0;
        repeat (256) step(1'b1, 5'd3, 12'h100);
        idle(1);
        @(negedge clk);
        chk("reconf_word", bus.out_data, 16'h1000);
        chk("reconf_busy_tail", busy, 1);
        bus.out_ready = 1'b1;
        idle(2);

        cfg_mode = 2'b11;
        repeat (4) step(1'b1, 5'd3, 12'h0AA);
        idle(2);
        @(negedge clk);
        chk("mode11_off", bus.out_valid, 0);

        cfg_mode = 2'b00;
        bus.out_ready = 1'b0;
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 5'd3, 12'(i + 1));
        idle(1);
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", bus.out_data, 16'h0010);
        rst = 1'b1;
        @(negedge clk);
        chk("ovf_rst_valid", bus.out_valid, 0);
        chk("ovf_rst_overflow", overflow, 0);
        chk("ovf_rst_busy", busy, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        step(1'b1, 5'd4, 12'h00F);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
